// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register.
// State encoding for the stage FSM and per-stage payload layouts with their kill-keep masks.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // IF/ID payload: pc, npc, instruction and decode control.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic [15:0] ctrl;
    } if_id_t;

    // MEM/WB payload: pc, instruction, writeback data, destination and control.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } mem_wb_t;

    // Killed entries keep pc and inst so the trap handler can identify the faulting instruction.
    localparam if_id_t IF_ID_KEEP = '{pc: '1, npc: '0, inst: '1, ctrl: '0};
    localparam mem_wb_t MEM_WB_KEEP = '{pc: '1, inst: '1, wb_data: '0, rd: '0, ctrl: '0};

endpackage

// File: rtl/pipe_skid_buf.sv
// One stage entry: payload register with its valid and exception flags.
// Written as a whole whenever i_we is high, otherwise holds.
module pipe_skid_buf #(
    parameter int unsigned PAYLOAD_W = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic                 i_valid,
    input  logic                 i_excp,
    input  logic [PAYLOAD_W-1:0] i_data,
    output logic                 o_valid,
    output logic                 o_excp,
    output logic [PAYLOAD_W-1:0] o_data
);

    logic                 r_valid;
    logic                 r_excp;
    logic [PAYLOAD_W-1:0] r_data;

    // Entry storage; cleared asynchronously, loaded on write enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_excp  <= 1'b0;
            r_data  <= '0;
        end else if (i_we) begin
            r_valid <= i_valid;
            r_excp  <= i_excp;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_excp  = r_excp;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, synchronous flush and
// exception kill. Define PIPE_SKID_EN for a 2-entry skid buffer with a registered ready_up;
// otherwise a single register with combinational ready_up.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          PAYLOAD_W   = 256,
    parameter logic [PAYLOAD_W-1:0] KEEP_MASK   = '0,
    parameter bit                   ZERO_BUBBLE = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_valid_up,
    output logic                 o_ready_up,
    input  logic                 i_kill_up,
    input  logic [PAYLOAD_W-1:0] i_data_up,
    output logic                 o_valid_dn,
    input  logic                 i_ready_dn,
    output logic [PAYLOAD_W-1:0] o_data_dn,
    output logic                 o_excp_dn
);

    logic                 w_acc;
    logic                 w_xfer;
    logic [PAYLOAD_W-1:0] w_up_data;
    logic [PAYLOAD_W-1:0] w_bubble_data;

    logic                 w_main_we;
    logic                 w_main_valid_d;
    logic                 w_main_excp_d;
    logic [PAYLOAD_W-1:0] w_main_data_d;

    assign w_acc  = i_valid_up & o_ready_up;
    assign w_xfer = o_valid_dn & i_ready_dn;

    // Killed entries keep only the masked fields; the rest are forced to zero.
    assign w_up_data     = i_kill_up ? (i_data_up & KEEP_MASK) : i_data_up;
    assign w_bubble_data = ZERO_BUBBLE ? '0 : o_data_dn;

    pipe_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_main (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_main_we),
        .i_valid (w_main_valid_d),
        .i_excp  (w_main_excp_d),
        .i_data  (w_main_data_d),
        .o_valid (o_valid_dn),
        .o_excp  (o_excp_dn),
        .o_data  (o_data_dn)
    );

`ifdef PIPE_SKID_EN

    pipe_state_e          r_state;
    pipe_state_e          w_state_d;
    logic                 r_ready_up;

    logic                 w_skid_we;
    logic                 w_skid_valid_d;
    logic                 w_skid_excp_d;
    logic [PAYLOAD_W-1:0] w_skid_data_d;
    logic                 w_skid_valid;
    logic                 w_skid_excp;
    logic [PAYLOAD_W-1:0] w_skid_data;

    pipe_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_skid_we),
        .i_valid (w_skid_valid_d),
        .i_excp  (w_skid_excp_d),
        .i_data  (w_skid_data_d),
        .o_valid (w_skid_valid),
        .o_excp  (w_skid_excp),
        .o_data  (w_skid_data)
    );

    assign o_ready_up = r_ready_up;

    // Next-state and entry routing; the skid entry always drains into main before new data.
    always_comb begin
        w_state_d      = r_state;
        w_main_we      = 1'b0;
        w_main_valid_d = o_valid_dn;
        w_main_excp_d  = o_excp_dn;
        w_main_data_d  = o_data_dn;
        w_skid_we      = 1'b0;
        w_skid_valid_d = 1'b0;
        w_skid_excp_d  = 1'b0;
        w_skid_data_d  = '0;
        if (i_flush) begin
            w_state_d      = EMPTY;
            w_main_we      = 1'b1;
            w_main_valid_d = 1'b0;
            w_main_excp_d  = 1'b0;
            w_main_data_d  = w_bubble_data;
            w_skid_we      = 1'b1;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_state_d      = BUSY;
                        w_main_we      = 1'b1;
                        w_main_valid_d = 1'b1;
                        w_main_excp_d  = i_kill_up;
                        w_main_data_d  = w_up_data;
                    end
                end
                BUSY: begin
                    if (w_acc && w_xfer) begin
                        w_main_we      = 1'b1;
                        w_main_valid_d = 1'b1;
                        w_main_excp_d  = i_kill_up;
                        w_main_data_d  = w_up_data;
                    end else if (w_acc) begin
                        w_state_d      = FULL;
                        w_skid_we      = 1'b1;
                        w_skid_valid_d = 1'b1;
                        w_skid_excp_d  = i_kill_up;
                        w_skid_data_d  = w_up_data;
                    end else if (w_xfer) begin
                        w_state_d      = EMPTY;
                        w_main_we      = 1'b1;
                        w_main_valid_d = 1'b0;
                        if (ZERO_BUBBLE) begin
                            w_main_excp_d = 1'b0;
                            w_main_data_d = '0;
                        end
                    end
                end
                FULL: begin
                    if (w_xfer) begin
                        w_state_d      = BUSY;
                        w_main_we      = 1'b1;
                        w_main_valid_d = w_skid_valid;
                        w_main_excp_d  = w_skid_excp;
                        w_main_data_d  = w_skid_data;
                        w_skid_we      = 1'b1;
                    end
                end
                default: begin
                    w_state_d = EMPTY;
                end
            endcase
        end
    end

    // FSM state and registered ready_up, which is low only while the skid entry is occupied.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= EMPTY;
            r_ready_up <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_ready_up <= (w_state_d != FULL);
        end
    end

`else

    // Single register: accept when empty or when the held entry leaves this cycle.
    assign o_ready_up = i_ready_dn | ~o_valid_dn;

    // Main entry update: flush, then accept (replacing a departing entry), then drain.
    always_comb begin
        w_main_we      = 1'b0;
        w_main_valid_d = o_valid_dn;
        w_main_excp_d  = o_excp_dn;
        w_main_data_d  = o_data_dn;
        if (i_flush) begin
            w_main_we      = 1'b1;
            w_main_valid_d = 1'b0;
            w_main_excp_d  = 1'b0;
            w_main_data_d  = w_bubble_data;
        end else if (w_acc) begin
            w_main_we      = 1'b1;
            w_main_valid_d = 1'b1;
            w_main_excp_d  = i_kill_up;
            w_main_data_d  = w_up_data;
        end else if (w_xfer) begin
            w_main_we      = 1'b1;
            w_main_valid_d = 1'b0;
            if (ZERO_BUBBLE) begin
                w_main_excp_d = 1'b0;
                w_main_data_d = '0;
            end
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a vector table for streaming/kill/bubble behaviour
// plus hand-written backpressure, flush, async reset and hold-data sequences.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid_up;
    logic        kill_up;
    logic        ready_dn;
    logic [31:0] data_up;

    logic        zb_ready_up;
    logic        zb_valid_dn;
    logic        zb_excp_dn;
    logic [31:0] zb_data_dn;
    logic        hd_ready_up;
    logic        hd_valid_dn;
    logic        hd_excp_dn;
    logic [31:0] hd_data_dn;

    int n_pass  = 0;
    int n_total = 0;

    pipe_stage_reg #(
        .PAYLOAD_W   (32),
        .KEEP_MASK   (32'h0000_00FF),
        .ZERO_BUBBLE (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_valid_up (valid_up),
        .o_ready_up (zb_ready_up),
        .i_kill_up  (kill_up),
        .i_data_up  (data_up),
        .o_valid_dn (zb_valid_dn),
        .i_ready_dn (ready_dn),
        .o_data_dn  (zb_data_dn),
        .o_excp_dn  (zb_excp_dn)
    );

    pipe_stage_reg #(
        .PAYLOAD_W   (32),
        .KEEP_MASK   (32'h0000_00FF),
        .ZERO_BUBBLE (1'b0)
    ) dut_hold (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_valid_up (valid_up),
        .o_ready_up (hd_ready_up),
        .i_kill_up  (kill_up),
        .i_data_up  (data_up),
        .o_valid_dn (hd_valid_dn),
        .i_ready_dn (ready_dn),
        .o_data_dn  (hd_data_dn),
        .o_excp_dn  (hd_excp_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        valid_up;
        logic        kill_up;
        logic        ready_dn;
        logic [31:0] data_up;
        logic        exp_valid;
        logic        exp_excp;
        logic [31:0] exp_data;
        logic        exp_ready;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive inputs just after a falling edge, then let combinational outputs settle.
    task automatic cycle(input logic f, input logic v, input logic k, input logic r,
                         input logic [31:0] d);
        @(negedge clk);
        flush    = f;
        valid_up = v;
        kill_up  = k;
        ready_dn = r;
        data_up  = d;
        #1;
    endtask

    logic [31:0] src [3];
    logic [31:0] rx  [$];
    int          idx;
    logic        exp_rdy;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_up = 1'b0;
        kill_up  = 1'b0;
        ready_dn = 1'b0;
        data_up  = '0;

        // Expected outputs are those visible in the same cycle the row's inputs are applied.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1,         1'b0, 1'b0, 32'h0,  1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h2,         1'b1, 1'b0, 32'h1,  1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h3,         1'b1, 1'b0, 32'h2,  1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h3,  1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h78, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,  1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE,      1'b0, 1'b0, 32'h0,  1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'hCAFE, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,  1'b1};

        @(negedge clk);
        #1;
        check("reset valid_dn", {31'b0, zb_valid_dn}, 32'h0);
        check("reset excp_dn", {31'b0, zb_excp_dn}, 32'h0);
        check("reset data_dn", zb_data_dn, 32'h0);
        check("reset ready_up", {31'b0, zb_ready_up}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Stream, kill and zero-bubble table.
        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].flush, vecs[i].valid_up, vecs[i].kill_up, vecs[i].ready_dn,
                  vecs[i].data_up);
            check($sformatf("vec%0d valid_dn", i), {31'b0, zb_valid_dn}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d excp_dn", i), {31'b0, zb_excp_dn}, {31'b0, vecs[i].exp_excp});
            check($sformatf("vec%0d data_dn", i), zb_data_dn, vecs[i].exp_data);
            check($sformatf("vec%0d ready_up", i), {31'b0, zb_ready_up}, {31'b0, vecs[i].exp_ready});
        end

        // Backpressure: A loaded, three stall cycles while B and C are offered.
        src[0] = 32'hA;
        src[1] = 32'hB;
        src[2] = 32'hC;
        idx = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b1, src[0]);
        if (valid_up && zb_ready_up) idx++;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, idx < 3, 1'b0, 1'b0, src[idx < 3 ? idx : 2]);
`ifdef PIPE_SKID_EN
            exp_rdy = (k == 0);
`else
            exp_rdy = 1'b0;
`endif
            check($sformatf("stall%0d valid_dn", k), {31'b0, zb_valid_dn}, 32'h1);
            check($sformatf("stall%0d data_dn", k), zb_data_dn, 32'hA);
            check($sformatf("stall%0d ready_up", k), {31'b0, zb_ready_up}, {31'b0, exp_rdy});
            if (valid_up && zb_ready_up) idx++;
        end
        for (int t = 0; t < 12 && rx.size() < 3; t++) begin
            cycle(1'b0, idx < 3, 1'b0, 1'b1, src[idx < 3 ? idx : 2]);
            if (zb_valid_dn && ready_dn) rx.push_back(zb_data_dn);
            if (valid_up && zb_ready_up) idx++;
        end
        check("release count", rx.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx.size()) check($sformatf("release order %0d", i), rx[i], src[i]);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("drained valid_dn", {31'b0, zb_valid_dn}, 32'h0);

        // Flush with a killed entry held, a second entry pending and a new one offered.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h11);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h22);
        check("preflush excp_dn", {31'b0, zb_excp_dn}, 32'h1);
        check("preflush data_dn", zb_data_dn, 32'h11);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h33);
        check("flush-cycle ready_up", {31'b0, zb_ready_up}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("postflush valid_dn", {31'b0, zb_valid_dn}, 32'h0);
        check("postflush excp_dn", {31'b0, zb_excp_dn}, 32'h0);
        check("postflush data_dn", zb_data_dn, 32'h0);
        check("postflush ready_up", {31'b0, zb_ready_up}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            check($sformatf("postflush%0d valid_dn", k), {31'b0, zb_valid_dn}, 32'h0);
        end

        // Async reset asserted between edges during a burst.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h41);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h42);
        check("burst data_dn", zb_data_dn, 32'h41);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid_dn", {31'b0, zb_valid_dn}, 32'h0);
        check("async rst data_dn", zb_data_dn, 32'h0);
        check("async rst ready_up", {31'b0, zb_ready_up}, 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h43);
        rst_n = 1'b1;
        #1;
        check("rst release valid_dn", {31'b0, zb_valid_dn}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("after rst valid_dn", {31'b0, zb_valid_dn}, 32'h1);
        check("after rst data_dn", zb_data_dn, 32'h43);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Drain without zero-bubble keeps the last payload.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h55);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("hold loaded valid_dn", {31'b0, hd_valid_dn}, 32'h1);
        check("hold loaded data_dn", hd_data_dn, 32'h55);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("hold drained valid_dn", {31'b0, hd_valid_dn}, 32'h0);
        check("hold drained data_dn", hd_data_dn, 32'h55);
        check("zb drained data_dn", zb_data_dn, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
